// File: rtl/vend_pkg.sv
// vend_pkg: shared coin values, coin encodings, error codes and change-dispenser state encoding
// Used by: change_coin_select, change_dispenser
//   NICKEL_C/DIME_C/QUARTER_C  coin values in cents
//   VEND_*                     5-bit one-hot vending coin set {dollar,half,quarter,dime,nickel}
//   COIN_*                     3-bit one-hot payout subset {quarter,dime,nickel}
//   ERR_*                      err_code values
//   cd_state_t                 dispenser FSM states
//   coin_value()               cents for a one-hot payout coin
package vend_pkg;
   localparam int NICKEL_C  = 5;
   localparam int DIME_C    = 10;
   localparam int QUARTER_C = 25;
   localparam logic [4:0] VEND_NICKEL  = 5'b00001;
   localparam logic [4:0] VEND_DIME    = 5'b00010;
   localparam logic [4:0] VEND_QUARTER = 5'b00100;
   localparam logic [4:0] VEND_HALF    = 5'b01000;
   localparam logic [4:0] VEND_DOLLAR  = 5'b10000;
   localparam logic [2:0] COIN_NONE = 3'b000;
   localparam logic [2:0] COIN_N    = 3'b001;
   localparam logic [2:0] COIN_D    = 3'b010;
   localparam logic [2:0] COIN_Q    = 3'b100;
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_BAD_AMT = 2'b01;
   localparam logic [1:0] ERR_NO_COIN = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;
   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_REQ, S_RELEASE, S_DONE, S_FAULT
   } cd_state_t;
   function automatic int coin_value(logic [2:0] coin);
      return coin[2] ? QUARTER_C : coin[1] ? DIME_C : coin[0] ? NICKEL_C : 0;
   endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: change request, hopper handshake and status signals of the change dispenser
//   master: upstream FSM / hopper side (drives chg_valid, chg_amount, tube_empty, disp_ack, clr_fault)
//   slave : change_dispenser (drives chg_ready, disp_req, disp_coin, busy, done, remaining, err_code)
interface change_dispenser_if #(parameter int AMT_W = 8);
   logic             chg_valid;
   logic             chg_ready;
   logic [AMT_W-1:0] chg_amount;
   logic [2:0]       tube_empty;
   logic             disp_req;
   logic [2:0]       disp_coin;
   logic             disp_ack;
   logic             busy;
   logic             done;
   logic [AMT_W-1:0] remaining;
   logic [1:0]       err_code;
   logic             clr_fault;
   modport master (
      output chg_valid, chg_amount, tube_empty, disp_ack, clr_fault,
      input  chg_ready, disp_req, disp_coin, busy, done, remaining, err_code
   );
   modport slave (
      input  chg_valid, chg_amount, tube_empty, disp_ack, clr_fault,
      output chg_ready, disp_req, disp_coin, busy, done, remaining, err_code
   );
endinterface

// File: rtl/change_coin_select.sv
// change_coin_select: greedy payout coin choice, largest available coin not exceeding the amount owed
//   remaining_i   cents still owed
//   tube_empty_i  {quarter,dime,nickel} empty sensors
//   coin_o        one-hot {quarter,dime,nickel}, 0 when nothing fits
//   value_o       cents of coin_o
//   none_o        no usable coin
module change_coin_select
   import vend_pkg::*;
#(
   parameter int AMT_W = 8
) (
   input  logic [AMT_W-1:0] remaining_i,
   input  logic [2:0]       tube_empty_i,
   output logic [2:0]       coin_o,
   output logic [AMT_W-1:0] value_o,
   output logic             none_o
);
   logic q_ok, d_ok, n_ok;
   always_comb begin
      q_ok    = !tube_empty_i[2] && remaining_i >= AMT_W'(QUARTER_C);
      d_ok    = !tube_empty_i[1] && remaining_i >= AMT_W'(DIME_C);
      n_ok    = !tube_empty_i[0] && remaining_i >= AMT_W'(NICKEL_C);
      coin_o  = q_ok ? COIN_Q : d_ok ? COIN_D : n_ok ? COIN_N : COIN_NONE;
      value_o = AMT_W'(coin_value(coin_o));
      none_o  = coin_o == COIN_NONE;
   end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out coin by coin through a req/ack hopper handshake
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    change_dispenser_if.slave: chg_valid/chg_ready/chg_amount request, tube_empty sensors,
//          disp_req/disp_coin/disp_ack hopper handshake, busy/done/remaining/err_code status, clr_fault
module change_dispenser
   import vend_pkg::*;
#(
   parameter int AMT_W       = 8,
   parameter int MAX_CHANGE  = 195,
   parameter int ACK_TIMEOUT = 1000
) (
   input logic                clk,
   input logic                rst_n,
   change_dispenser_if.slave  bus
);
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   cd_state_t        state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d, val_q, val_d, sel_val;
   logic [2:0]       coin_q, coin_d, sel_coin;
   logic [1:0]       err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_none, bad_amt;
   change_coin_select #(.AMT_W(AMT_W)) u_sel (
      .remaining_i  (rem_q),
      .tube_empty_i (bus.tube_empty),
      .coin_o       (sel_coin),
      .value_o      (sel_val),
      .none_o       (sel_none)
   );
   assign bad_amt = (int'(bus.chg_amount) % NICKEL_C != 0) || (int'(bus.chg_amount) > MAX_CHANGE);
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      val_d   = val_q;
      coin_d  = coin_q;
      err_d   = err_q;
      cnt_d   = '0;
      case (state_q)
         S_IDLE: if (bus.chg_valid) begin
            rem_d   = bus.chg_amount;
            state_d = bad_amt ? S_FAULT : S_SELECT;
            err_d   = bad_amt ? ERR_BAD_AMT : ERR_NONE;
         end
         S_SELECT: begin
            coin_d  = sel_coin;
            val_d   = sel_val;
            state_d = rem_q == '0 ? S_DONE : sel_none ? S_FAULT : S_REQ;
            err_d   = (rem_q != '0 && sel_none) ? ERR_NO_COIN : ERR_NONE;
         end
         S_REQ: begin
            // cnt_q counts completed REQ cycles; the fault fires on the last allowed one,
            // and an ack seen in that same cycle takes priority
            cnt_d = cnt_q == CNT_W'(ACK_TIMEOUT) ? cnt_q : cnt_q + 1'b1;
            if (bus.disp_ack) begin
               rem_d   = rem_q - val_q;
               state_d = S_RELEASE;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               state_d = S_FAULT;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_RELEASE: state_d = bus.disp_ack ? S_RELEASE : S_SELECT;
         S_DONE: begin
            rem_d   = '0;
            state_d = S_IDLE;
         end
         S_FAULT: if (bus.clr_fault) begin
            state_d = S_IDLE;
            err_d   = ERR_NONE;
            rem_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         val_q   <= '0;
         coin_q  <= '0;
         err_q   <= ERR_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         val_q   <= val_d;
         coin_q  <= coin_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
   assign bus.chg_ready = state_q == S_IDLE;
   assign bus.busy      = state_q != S_IDLE;
   assign bus.disp_req  = state_q == S_REQ;
   assign bus.disp_coin = state_q == S_REQ ? coin_q : '0;
   assign bus.done      = state_q == S_DONE;
   assign bus.remaining = rem_q;
   assign bus.err_code  = err_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed vector table plus hand-written corner sequences for change_dispenser
module tb_change_dispenser;
   import vend_pkg::*;
   localparam int TO = 1000;
   typedef struct {
      int         amt;
      logic [2:0] empty;
      string      coins;
      int         err;
      int         rem;
   } vec_t;
   logic clk = 0;
   logic rst_n = 0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   change_dispenser_if #(.AMT_W(8)) bus ();
   change_dispenser #(.AMT_W(8), .MAX_CHANGE(195), .ACK_TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic chks(input string nm, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
      end
   endtask
   function automatic string cname(input logic [2:0] c);
      return c == COIN_Q ? "Q" : c == COIN_D ? "D" : c == COIN_N ? "N" : "?";
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic accept(input int amt, input logic [2:0] empty);
      bus.tube_empty = empty;
      bus.chg_amount = 8'(amt);
      bus.chg_valid  = 1;
      tick();
      bus.chg_valid  = 0;
   endtask
   // one transaction with a hopper that acks two samples after seeing a request;
   // spam keeps offering a new request whenever the dispenser is busy
   task automatic run(input string nm, input int amt, input logic [2:0] empty, input bit spam,
                      output string coins, output int err, output int rem, output int dones);
      int cyc = 0;
      int dly = 0;
      bit fin = 0;
      coins = "";
      dones = 0;
      accept(amt, empty);
      while (!fin && cyc < 3000) begin
         if (bus.disp_req && !bus.disp_ack) begin
            if (dly == 0) coins = {coins, cname(bus.disp_coin)};
            dly++;
            if (dly == 2) bus.disp_ack = 1;
         end else if (!bus.disp_req && bus.disp_ack) begin
            bus.disp_ack = 0;
            dly = 0;
         end
         if (bus.done) begin
            dones++;
            fin = 1;
         end
         if (bus.err_code != 0) fin = 1;
         if (spam && !fin) begin
            bus.chg_valid  = bus.busy;
            bus.chg_amount = 8'd50;
         end
         if (!fin) begin
            tick();
            cyc++;
         end
      end
      if (!fin) chk({nm, "_finish_bound"}, cyc, -1);
      err = bus.err_code;
      rem = bus.remaining;
      if (dones != 0) begin
         tick();
         bus.chg_valid = 0;
         dones += bus.done;
         chk({nm, "_ready_after_done"}, bus.chg_ready, 1);
         chk({nm, "_rem_after_done"}, bus.remaining, 0);
      end
      bus.chg_valid = 0;
   endtask
   task automatic clear_fault(input string nm);
      bus.clr_fault = 1;
      tick();
      bus.clr_fault = 0;
      chk({nm, "_clr_ready"}, bus.chg_ready, 1);
      chk({nm, "_clr_err"}, bus.err_code, 0);
      chk({nm, "_clr_rem"}, bus.remaining, 0);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      vec_t  v[12];
      string coins;
      int    err, rem, dones, cnt, cyc;
      bit    seen;
      v[0]  = '{65,  3'b000, "QQDN",      0, 0};
      v[1]  = '{30,  3'b100, "DDD",       0, 0};
      v[2]  = '{15,  3'b011, "",          2, 15};
      v[3]  = '{7,   3'b000, "",          1, 7};
      v[4]  = '{200, 3'b000, "",          1, 200};
      v[5]  = '{0,   3'b000, "",          0, 0};
      v[6]  = '{40,  3'b010, "QNNN",      0, 0};
      v[7]  = '{20,  3'b001, "DD",        0, 0};
      v[8]  = '{35,  3'b100, "DDDN",      0, 0};
      v[9]  = '{30,  3'b011, "Q",         2, 5};
      v[10] = '{195, 3'b000, "QQQQQQQDD", 0, 0};
      v[11] = '{5,   3'b001, "",          2, 5};
      bus.chg_valid  = 0;
      bus.chg_amount = 0;
      bus.tube_empty = 0;
      bus.disp_ack   = 0;
      bus.clr_fault  = 0;
      #12;
      chk("rst_chg_ready", bus.chg_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_disp_req", bus.disp_req, 0);
      chk("rst_disp_coin", bus.disp_coin, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_remaining", bus.remaining, 0);
      chk("rst_err_code", bus.err_code, 0);
      rst_n = 1;
      tick();
      for (int i = 0; i < 12; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         run(nm, v[i].amt, v[i].empty, 0, coins, err, rem, dones);
         chks({nm, "_coins"}, coins, v[i].coins);
         chk({nm, "_err"}, err, v[i].err);
         chk({nm, "_rem"}, rem, v[i].rem);
         chk({nm, "_done_pulses"}, dones, v[i].err == 0 ? 1 : 0);
         if (v[i].err != 0) begin
            chk({nm, "_fault_ready"}, bus.chg_ready, 0);
            chk({nm, "_fault_busy"}, bus.busy, 1);
            clear_fault(nm);
         end
      end
      // hopper never acks: request held for exactly the timeout, then fault
      accept(25, 3'b000);
      cnt = 0;
      cyc = 0;
      while (bus.err_code == 0 && cyc < 1200) begin
         if (bus.disp_req) cnt++;
         tick();
         cyc++;
      end
      chk("to_req_cycles", cnt, TO);
      chk("to_err", bus.err_code, 3);
      chk("to_rem", bus.remaining, 25);
      chk("to_disp_req", bus.disp_req, 0);
      chk("to_ready", bus.chg_ready, 0);
      bus.disp_ack = 1;
      tick();
      bus.disp_ack = 0;
      chk("to_ack_ignored_rem", bus.remaining, 25);
      chk("to_ack_ignored_err", bus.err_code, 3);
      clear_fault("to");
      // ack arrives in the very cycle the timeout expires: coin counted, no fault
      accept(25, 3'b000);
      cnt = 0;
      cyc = 0;
      while (cyc < 1200) begin
         if (bus.disp_req) cnt++;
         if (cnt == TO) break;
         tick();
         cyc++;
      end
      chk("edge_req_cycles", cnt, TO);
      bus.disp_ack = 1;
      tick();
      chk("edge_err", bus.err_code, 0);
      chk("edge_disp_req", bus.disp_req, 0);
      chk("edge_rem", bus.remaining, 0);
      chk("edge_busy", bus.busy, 1);
      bus.disp_ack = 0;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         tick();
         seen = bus.done;
      end
      chk("edge_done", seen, 1);
      tick();
      // zero amount: done exactly two cycles after the accept edge, no request
      bus.chg_amount = 0;
      bus.chg_valid  = 1;
      tick();
      bus.chg_valid  = 0;
      chk("zero_c1_done", bus.done, 0);
      chk("zero_c1_req", bus.disp_req, 0);
      tick();
      chk("zero_c2_done", bus.done, 1);
      chk("zero_c2_req", bus.disp_req, 0);
      tick();
      // asynchronous reset in the middle of a payout
      accept(65, 3'b000);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         seen = bus.disp_req;
         if (!seen) tick();
      end
      chk("rst_mid_req_seen", seen, 1);
      #2 rst_n = 0;
      #1;
      chk("rst_mid_disp_req", bus.disp_req, 0);
      chk("rst_mid_ready", bus.chg_ready, 1);
      tick();
      rst_n = 1;
      tick();
      chk("rst_mid_after_ready", bus.chg_ready, 1);
      chk("rst_mid_after_rem", bus.remaining, 0);
      chk("rst_mid_after_busy", bus.busy, 0);
      // new requests offered while busy must never be taken
      run("spam", 10, 3'b000, 1, coins, err, rem, dones);
      chks("spam_coins", coins, "D");
      chk("spam_err", err, 0);
      chk("spam_rem", rem, 0);
      chk("spam_done_pulses", dones, 1);
      tick();
      chk("spam_no_accept", bus.busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
